// File: rtl/scan_ctl_145_if.sv
// Signal bundle between the sn74ls145 scan controller and its keypad/decoder side.
// The master modport is the controller; the slave modport is whatever drives en/ret_n.
interface scan_ctl_145_if;
  logic       en;
  logic       ret_n;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic [3:0] dig;
  logic       load;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  en, ret_n,
    output a, b, c, d, dig, load, key_code, key_valid, key_held
  );

  modport slave (
    output en, ret_n,
    input  a, b, c, d, dig, load, key_code, key_valid, key_held
  );
endinterface

// File: rtl/scan_ctl_145.sv
// Digit scanner for an sn74ls145 BCD decoder with blanking, dwell timing and a
// two-frame debounced key detector on the shared active-low return line.
module scan_ctl_145 #(
  parameter int DIGITS = 10,
  parameter int DWELL  = 16,
  parameter int BLANK  = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  scan_ctl_145_if.master io_bus
);

  if (DIGITS < 2 || DIGITS > 10) begin : g_badDigits
    $fatal(1, "scan_ctl_145: DIGITS must be in 2..10");
  end
  if (DWELL < 2 || DWELL > 255) begin : g_badDwell
    $fatal(1, "scan_ctl_145: DWELL must be in 2..255");
  end
  if (BLANK < 1 || BLANK > 255) begin : g_badBlank
    $fatal(1, "scan_ctl_145: BLANK must be in 1..255");
  end

  localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] DIG_LAST   = 4'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;

  state_t     r_state, w_state;
  logic [7:0] r_cnt, w_cnt;
  logic [3:0] r_dig, w_dig;
  logic [3:0] r_code, w_code;
  logic       r_load, w_load;
  logic       r_candValid, w_candValid;
  logic [3:0] r_cand, w_cand;
  logic       r_prevValid, w_prevValid;
  logic [3:0] r_prev, w_prev;
  logic [3:0] r_keyCode, w_keyCode;
  logic       r_keyValid, w_keyValid;
  logic       r_keyHeld, w_keyHeld;
  logic       w_frameCandValid;
  logic [3:0] w_frameCand;

  always_comb begin
    w_state          = r_state;
    w_cnt            = r_cnt;
    w_dig            = r_dig;
    w_code           = 4'hF;
    w_load           = 1'b0;
    w_candValid      = r_candValid;
    w_cand           = r_cand;
    w_prevValid      = r_prevValid;
    w_prev           = r_prev;
    w_keyCode        = r_keyCode;
    w_keyValid       = 1'b0;
    w_keyHeld        = r_keyHeld;
    w_frameCandValid = 1'b0;
    w_frameCand      = r_cand;

    if (!io_bus.en) begin
      w_state     = S_IDLE;
      w_cnt       = 8'd0;
      w_candValid = 1'b0;
      w_cand      = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state = S_BLANK;
          w_cnt   = 8'd0;
        end
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state = S_DWELL;
            w_cnt   = 8'd0;
            w_code  = r_dig;
            w_load  = 1'b1;
          end else begin
            w_cnt = r_cnt + 8'd1;
          end
        end
        S_DWELL: begin
          if (r_cnt == DWELL_LAST) begin
            w_state = S_BLANK;
            w_cnt   = 8'd0;
            // Digits are scanned upward, so the first closed digit in a frame is the lowest.
            w_frameCandValid = r_candValid || !io_bus.ret_n;
            w_frameCand      = r_candValid ? r_cand : r_dig;
            if (r_dig == DIG_LAST) begin
              w_dig       = 4'd0;
              w_candValid = 1'b0;
              w_cand      = 4'd0;
              if (w_frameCandValid) begin
                if (r_prevValid && (r_prev == w_frameCand) && !r_keyHeld) begin
                  w_keyValid = 1'b1;
                  w_keyCode  = w_frameCand;
                  w_keyHeld  = 1'b1;
                end
                w_prevValid = 1'b1;
                w_prev      = w_frameCand;
              end else begin
                w_keyHeld   = 1'b0;
                w_prevValid = 1'b0;
                w_prev      = 4'd0;
              end
            end else begin
              w_dig       = r_dig + 4'd1;
              w_candValid = w_frameCandValid;
              w_cand      = w_frameCand;
            end
          end else begin
            w_cnt  = r_cnt + 8'd1;
            w_code = r_dig;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_dig       <= 4'd0;
      r_code      <= 4'hF;
      r_load      <= 1'b0;
      r_candValid <= 1'b0;
      r_cand      <= 4'd0;
      r_prevValid <= 1'b0;
      r_prev      <= 4'd0;
      r_keyCode   <= 4'd0;
      r_keyValid  <= 1'b0;
      r_keyHeld   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_dig       <= w_dig;
      r_code      <= w_code;
      r_load      <= w_load;
      r_candValid <= w_candValid;
      r_cand      <= w_cand;
      r_prevValid <= w_prevValid;
      r_prev      <= w_prev;
      r_keyCode   <= w_keyCode;
      r_keyValid  <= w_keyValid;
      r_keyHeld   <= w_keyHeld;
    end
  end

  assign {io_bus.d, io_bus.c, io_bus.b, io_bus.a} = r_code;
  assign io_bus.dig       = r_dig;
  assign io_bus.load      = r_load;
  assign io_bus.key_code  = r_keyCode;
  assign io_bus.key_valid = r_keyValid;
  assign io_bus.key_held  = r_keyHeld;

endmodule

// File: tb/tb_scan_ctl_145.sv
// Bench for scan_ctl_145: default instance for scan timing and debounce scenarios,
// plus a small DIGITS=4/DWELL=2/BLANK=1 instance; key pulses are matched against a queue.
module tb_scan_ctl_145;
  localparam int SLOT  = 18;
  localparam int FRAME = 180;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n      = 1'b0;
  logic rstSmall_n = 1'b0;

  scan_ctl_145_if bus ();
  scan_ctl_145_if busSmall ();

  scan_ctl_145 dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  scan_ctl_145 #(.DIGITS(4), .DWELL(2), .BLANK(1)) dutSmall (
    .i_clk   (clk),
    .i_rst_n (rstSmall_n),
    .io_bus  (busSmall)
  );

  typedef struct {
    logic [9:0] mask1;
    logic [9:0] mask2;
    int         pulses;
    int         code;
  } vec_t;

  int         nChecks = 0;
  int         nPass   = 0;
  logic [3:0] expQ[$];

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Inputs change just after the edge; outputs are observed at the following falling edge.
  task automatic applyStimulus(input logic r, input logic e, input logic ret);
    @(posedge clk);
    #1;
    rst_n      = r;
    bus.en     = e;
    bus.ret_n  = ret;
    busSmall.en    = 1'b0;
    busSmall.ret_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic applySmall(input logic r, input logic e, input logic ret);
    @(posedge clk);
    #1;
    rstSmall_n     = r;
    busSmall.en    = e;
    busSmall.ret_n = ret;
    bus.en         = 1'b0;
    bus.ret_n      = 1'b1;
    @(negedge clk);
  endtask

  task automatic startScan();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("reset code", {bus.d, bus.c, bus.b, bus.a}, 15);
    checkOutput("reset dig", bus.dig, 0);
    checkOutput("reset load", bus.load, 0);
    checkOutput("reset key_valid", bus.key_valid, 0);
    checkOutput("reset key_held", bus.key_held, 0);
    checkOutput("reset key_code", bus.key_code, 0);
  endtask

  task automatic scanCycles(input int nCyc, input logic [9:0] m1, input logic [9:0] m2,
                            input int expHeld);
    for (int k = 0; k < nCyc; k++) begin
      int d;
      int pos;
      int fr;
      logic press;
      logic [3:0] e;
      d     = (k / SLOT) % 10;
      pos   = k % SLOT;
      fr    = k / FRAME;
      press = (pos >= 2) && (((fr == 0) && m1[d]) || ((fr == 1) && m2[d]));
      applyStimulus(1'b1, 1'b1, !press);
      checkOutput("scan code", {bus.d, bus.c, bus.b, bus.a}, (pos < 2) ? 15 : d);
      checkOutput("scan load", bus.load, (pos == 2) ? 1 : 0);
      if (pos >= 2) checkOutput("scan dig", bus.dig, d);
      if (bus.key_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected key_valid", bus.key_valid, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("key_code on pulse", bus.key_code, e);
          checkOutput("key_valid cycle", k, 2 * FRAME);
          checkOutput("key_held on pulse", bus.key_held, 1);
        end
      end
      if (expHeld >= 0 && k == 2 * FRAME + 1) checkOutput("key_held after frame 2", bus.key_held, expHeld);
      if (expHeld >= 0 && k == 3 * FRAME + 1) checkOutput("key_held after idle frame", bus.key_held, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[6];
    logic [3:0] e;

    bus.en = 1'b0;  bus.ret_n = 1'b1;
    busSmall.en = 1'b0;  busSmall.ret_n = 1'b1;

    vecs[0] = '{10'h000, 10'h000, 0, 0};
    vecs[1] = '{10'h080, 10'h080, 1, 7};
    vecs[2] = '{10'h088, 10'h088, 1, 3};
    vecs[3] = '{10'h004, 10'h020, 0, 0};
    vecs[4] = '{10'h001, 10'h001, 1, 0};
    vecs[5] = '{10'h200, 10'h200, 1, 9};

    for (int v = 0; v < 6; v++) begin
      $display("[TB] vector %0d", v);
      startScan();
      if (vecs[v].pulses != 0) expQ.push_back(4'(vecs[v].code));
      scanCycles(3 * FRAME + 2, vecs[v].mask1, vecs[v].mask2, vecs[v].pulses);
      checkOutput("pending key pulses", expQ.size(), 0);
      if (vecs[v].pulses != 0) checkOutput("key_code retained", bus.key_code, vecs[v].code);
      expQ.delete();
    end

    $display("[TB] en dropped mid-dwell of digit 5");
    startScan();
    scanCycles(100, 10'h000, 10'h000, -1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("code before en drop", {bus.d, bus.c, bus.b, bus.a}, 5);
    for (int j = 0; j < 9; j++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("code while disabled", {bus.d, bus.c, bus.b, bus.a}, 15);
      checkOutput("load while disabled", bus.load, 0);
    end
    for (int j = 0; j < 20; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("code after re-enable", {bus.d, bus.c, bus.b, bus.a}, (j >= 3 && j <= 18) ? 5 : 15);
      checkOutput("load after re-enable", bus.load, (j == 3) ? 1 : 0);
      checkOutput("key_valid after re-enable", bus.key_valid, 0);
    end

    $display("[TB] reset during dwell of digit 4 with key held");
    startScan();
    expQ.push_back(4'd7);
    scanCycles(2 * FRAME + 4 * SLOT + 5, 10'h080, 10'h080, 1);
    checkOutput("pending key pulses", expQ.size(), 0);
    checkOutput("key_held before reset", bus.key_held, 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("code after reset", {bus.d, bus.c, bus.b, bus.a}, 15);
    checkOutput("dig after reset", bus.dig, 0);
    checkOutput("key_held after reset", bus.key_held, 0);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("resume code", {bus.d, bus.c, bus.b, bus.a}, (j == 2) ? 0 : 15);
      checkOutput("resume load", bus.load, (j == 2) ? 1 : 0);
    end
    expQ.delete();

    $display("[TB] frame end coinciding with en drop");
    startScan();
    scanCycles(2 * FRAME - 1, 10'h200, 10'h200, -1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("code at last dwell", {bus.d, bus.c, bus.b, bus.a}, 9);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("key_valid after dropped frame", bus.key_valid, 0);
      checkOutput("key_held after dropped frame", bus.key_held, 0);
      checkOutput("code after dropped frame", {bus.d, bus.c, bus.b, bus.a}, 15);
    end

    $display("[TB] small instance DIGITS=4 DWELL=2 BLANK=1");
    applySmall(1'b0, 1'b0, 1'b1);
    applySmall(1'b1, 1'b1, 1'b1);
    checkOutput("small reset code", {busSmall.d, busSmall.c, busSmall.b, busSmall.a}, 15);
    expQ.push_back(4'd2);
    for (int k = 0; k < 3 * 12 + 1; k++) begin
      int d;
      int pos;
      logic press;
      d     = (k / 3) % 4;
      pos   = k % 3;
      press = (d == 2) && (pos == 2) && (k / 12 < 2);
      applySmall(1'b1, 1'b1, !press);
      checkOutput("small code", {busSmall.d, busSmall.c, busSmall.b, busSmall.a}, (pos == 0) ? 15 : d);
      checkOutput("small load", busSmall.load, (pos == 1) ? 1 : 0);
      if (pos != 0) checkOutput("small dig", busSmall.dig, d);
      if (busSmall.key_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("small unexpected key_valid", busSmall.key_valid, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("small key_code", busSmall.key_code, e);
          checkOutput("small key_valid cycle", k, 24);
        end
      end
    end
    checkOutput("small pending key pulses", expQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/scan_ctl_145.md
SCAN_CTL_145 -- requirements
Module: scan_ctl_145

Interface
REQ-001 Parameter DIGITS, default 10: number of scanned positions. Legal range 2..10.
REQ-002 Parameter DWELL, default 16: clock cycles a digit code is driven. Legal range 2..255.
REQ-003 Parameter BLANK, default 2: clock cycles of blanking before each digit. Legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 en  input  1  scan enable, active-high.
REQ-007 ret_n  input  1  key-return line, active-low; low means the key on the selected decoder output is closed.
REQ-008 a, b, c, d  output  1 each  BCD code to the sn74ls145 inputs; d is the MSB.
REQ-009 dig  output  4  index of the digit currently in dwell.
REQ-010 load  output  1  one-cycle pulse on the first dwell cycle of each digit.
REQ-011 key_code  output  4  digit index of the last validated key.
REQ-012 key_valid  output  1  one-cycle pulse when key_code is updated.
REQ-013 key_held  output  1  high while the validated key remains closed.

Function
REQ-014 States: IDLE, BLANK and DWELL. All outputs are registered.
REQ-015 In IDLE and BLANK, {d,c,b,a} = 4'b1111. This is an invalid BCD code, so all decoder outputs are off.
REQ-016 In DWELL, {d,c,b,a} = dig.
REQ-017 IDLE -> BLANK when en=1. The next digit is 0 on the first entry after reset, otherwise the stored digit.
REQ-018 BLANK lasts exactly BLANK cycles, then goes to DWELL.
REQ-019 DWELL lasts exactly DWELL cycles, then goes to BLANK with dig advanced by 1.
REQ-020 dig wraps DIGITS-1 -> 0. A wrap marks the end of a frame, so frame length = DIGITS*(BLANK+DWELL) cycles.
REQ-021 load is high for exactly the first cycle of each DWELL, when {d,c,b,a} already shows the new digit.
REQ-022 en=0 in any state -> IDLE on the next edge, with {d,c,b,a}=1111 from that edge.
  - The digit index is retained.
  - The dwell/blank counter is cleared.
  - The frame scan record is discarded.
  - Re-enabling restarts with BLANK at the retained digit.
REQ-023 ret_n is sampled only on the last DWELL cycle of each digit. Within a frame, the lowest sampled digit with ret_n=0 is the frame candidate.
REQ-024 Debounce. At the end of a frame, key_valid pulses for one cycle and key_code is set to the candidate only if all of the following hold:
  - the current frame has a candidate;
  - it equals the previous frame's candidate;
  - key_held=0.
  key_held is set in the same cycle.
REQ-025 At the end of a frame with no candidate, key_held clears and the previous-frame candidate is cleared. No pulse is generated.
REQ-026 A different candidate while key_held=1 gives no pulse. It becomes the new previous-frame candidate, and key_held stays set until a frame with no candidate.
REQ-027 Simultaneous frame end and en falling edge: en has priority. The frame is discarded, with no key_valid and no key_held change.
REQ-028 Illegal parameter values are rejected at elaboration with a fatal message.

Reset
REQ-029 rst_n=0 on a rising edge forces the following on that edge, regardless of state or en:
  - state=IDLE, {d,c,b,a}=1111, dig=0;
  - counter=0, frame candidate cleared, previous candidate cleared;
  - load=0, key_valid=0, key_held=0, key_code=0.
REQ-030 Reset mid-DWELL or mid-BLANK aborts the digit immediately. After release with en=1, the scan begins at BLANK of digit 0.

Verification
REQ-031 Defaults, en=1, ret_n=1 -> {d,c,b,a} sequence is 1111 x2, 0000 x16, 1111 x2, 0001 x16 ... 1001 x16, then wraps to 0000. load pulses every 18 cycles, frame=180 cycles, key_valid never pulses.
REQ-032 ret_n=0 exactly during dwell of digit 7 for 2 consecutive frames -> one key_valid pulse at the end of frame 2 with key_code=7 and key_held=1. With no later frame, no further pulse; key_held=0 after the first frame without a press.
REQ-033 ret_n=0 during digits 3 and 7 for 2 frames -> key_code=3. One pulse only.
REQ-034 en dropped mid-dwell of digit 5 for 10 cycles -> 1111 on the next edge. On re-enable: 2 blank cycles, then 0101 for 16 cycles; no key event.
REQ-035 rst_n=0 for 1 cycle during dwell of digit 4 with key_held=1 -> next cycle {d,c,b,a}=1111, dig=0, key_held=0. The scan resumes at digit 0.
REQ-036 DIGITS=4, DWELL=2, BLANK=1 -> dig sequence 0,1,2,3,0 with frame=12 cycles. A pulse on ret_n at the last dwell cycle of digit 2 for 2 frames -> key_code=2.
